// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer:
// FSM states, instruction classes, control codes and instr_bus bit positions.
package core_ctrl_pkg;

    localparam int INSTR_W = 38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } instr_class_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_JALR  = 2'd2
    } pc_sel_t;

    // Bit positions inside the one-hot instr_bus; classes occupy contiguous ranges.
    localparam logic [5:0] BIT_SLTU  = 6'd9;
    localparam logic [5:0] BIT_ADDI  = 6'd10;
    localparam logic [5:0] BIT_SLTUI = 6'd18;
    localparam logic [5:0] BIT_LHU   = 6'd23;
    localparam logic [5:0] BIT_SW    = 6'd26;
    localparam logic [5:0] BIT_BNE   = 6'd28;
    localparam logic [5:0] BIT_BGE   = 6'd30;
    localparam logic [5:0] BIT_BGEU  = 6'd32;
    localparam logic [5:0] BIT_JAL   = 6'd33;
    localparam logic [5:0] BIT_JALR  = 6'd34;
    localparam logic [5:0] BIT_LUI   = 6'd35;
    localparam int         BIT_RSVD  = 37;

endpackage

// File: rtl/core_ctrl_fsm_instr_class_enc.sv
// Combinational classifier: one-hot decoded instruction to class, ALU controls,
// write-back controls and a legality flag (exactly one bit set, reserved bit clear).
module instr_class_enc
    import core_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output instr_class_t       o_class,
    output logic [3:0]         o_alu_op,
    output logic               o_alu_src_imm,
    output logic               o_reg_we,
    output logic [1:0]         o_wb_sel,
    output logic               o_br_inv,
    output logic               o_legal
);

    logic [5:0] w_idx;
    logic       w_legal;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < INSTR_W; i++) begin
            if (i_instr[i]) begin
                w_idx = 6'(i);
            end
        end
    end

    assign w_legal = ($countones(i_instr) == 1) && !i_instr[BIT_RSVD];
    assign o_legal = w_legal;

    // Immediate ALU ops skip SUB, so bits 11..18 map onto ALU codes 2..9.
    always_comb begin
        o_class       = CLS_NONE;
        o_alu_op      = ALU_ADD;
        o_alu_src_imm = 1'b0;
        o_reg_we      = 1'b0;
        o_wb_sel      = WB_ALU;
        o_br_inv      = 1'b0;
        if (w_legal) begin
            if (w_idx <= BIT_SLTU) begin
                o_class  = CLS_R;
                o_alu_op = 4'(w_idx);
                o_reg_we = 1'b1;
            end else if (w_idx <= BIT_SLTUI) begin
                o_class       = CLS_I;
                o_alu_op      = (w_idx == BIT_ADDI) ? ALU_ADD : 4'(w_idx - 6'd9);
                o_alu_src_imm = 1'b1;
                o_reg_we      = 1'b1;
            end else if (w_idx <= BIT_LHU) begin
                o_class       = CLS_LOAD;
                o_alu_src_imm = 1'b1;
                o_reg_we      = 1'b1;
                o_wb_sel      = WB_MEM;
            end else if (w_idx <= BIT_SW) begin
                o_class       = CLS_STORE;
                o_alu_src_imm = 1'b1;
            end else if (w_idx <= BIT_BGEU) begin
                o_class = CLS_BRANCH;
                if (w_idx <= BIT_BNE) begin
                    o_alu_op = ALU_SUB;
                end else if (w_idx <= BIT_BGE) begin
                    o_alu_op = ALU_SLT;
                end else begin
                    o_alu_op = ALU_SLTU;
                end
                o_br_inv = (w_idx == BIT_BNE) || (w_idx == BIT_BGE) || (w_idx == BIT_BGEU);
            end else if (w_idx == BIT_JAL) begin
                o_class  = CLS_JAL;
                o_reg_we = 1'b1;
                o_wb_sel = WB_PC4;
            end else if (w_idx == BIT_JALR) begin
                o_class       = CLS_JALR;
                o_alu_src_imm = 1'b1;
                o_reg_we      = 1'b1;
                o_wb_sel      = WB_PC4;
            end else if (w_idx == BIT_LUI) begin
                o_class       = CLS_LUI;
                o_alu_src_imm = 1'b1;
                o_reg_we      = 1'b1;
                o_wb_sel      = WB_IMM;
            end else begin
                o_class       = CLS_AUIPC;
                o_alu_src_imm = 1'b1;
                o_reg_we      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch handshake, decode wait, execute,
// data-memory access and write-back, with request timeouts and a sticky trap.
module core_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int unsigned DECODE_LAT  = 2,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_halt_req,
    output logic               o_imem_req,
    input  logic               i_imem_ready,
    output logic               o_ir_load,
    input  logic [INSTR_W-1:0] i_instr_bus,
    input  logic               i_branch_taken,
    output logic [3:0]         o_alu_op,
    output logic               o_alu_src_imm,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    input  logic               i_dmem_ready,
    output logic               o_reg_we,
    output logic [1:0]         o_wb_sel,
    output logic               o_pc_we,
    output logic [1:0]         o_pc_sel,
    output logic               o_trap,
    output logic               o_busy,
    output logic               o_retired,
    output logic [31:0]        o_retire_count
);

    localparam logic [7:0] DEC_LIMIT = 8'(DECODE_LAT - 1);
    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t       r_state;
    logic [7:0]   r_wait;
    instr_class_t r_cls;
    logic         r_reg_we;
    logic [1:0]   r_wb_sel;
    logic         r_br_inv;

    instr_class_t w_class;
    logic [3:0]   w_alu_op;
    logic         w_alu_src_imm;
    logic         w_reg_we;
    logic [1:0]   w_wb_sel;
    logic         w_br_inv;
    logic         w_legal;
    logic [1:0]   w_pc_sel;

    // Classified from the live bus on the last DECODE cycle so EXEC controls are registered.
    instr_class_enc u_enc (
        .i_instr       (i_instr_bus),
        .o_class       (w_class),
        .o_alu_op      (w_alu_op),
        .o_alu_src_imm (w_alu_src_imm),
        .o_reg_we      (w_reg_we),
        .o_wb_sel      (w_wb_sel),
        .o_br_inv      (w_br_inv),
        .o_legal       (w_legal)
    );

    assign o_ir_load = (r_state == ST_FETCH) && i_imem_ready;
    assign o_busy    = (r_state != ST_IDLE) && (r_state != ST_TRAP);

    always_comb begin
        w_pc_sel = PC_PLUS4;
        case (r_cls)
            CLS_JAL:    w_pc_sel = PC_IMM;
            CLS_JALR:   w_pc_sel = PC_JALR;
            CLS_BRANCH: w_pc_sel = (i_branch_taken ^ r_br_inv) ? PC_IMM : PC_PLUS4;
            default:    w_pc_sel = PC_PLUS4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wait         <= '0;
            r_cls          <= CLS_NONE;
            r_reg_we       <= 1'b0;
            r_wb_sel       <= '0;
            r_br_inv       <= 1'b0;
            o_imem_req     <= 1'b0;
            o_alu_op       <= '0;
            o_alu_src_imm  <= 1'b0;
            o_dmem_req     <= 1'b0;
            o_dmem_we      <= 1'b0;
            o_reg_we       <= 1'b0;
            o_wb_sel       <= '0;
            o_pc_we        <= 1'b0;
            o_pc_sel       <= '0;
            o_trap         <= 1'b0;
            o_retired      <= 1'b0;
            o_retire_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_FETCH;
                        r_wait     <= '0;
                        o_imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (i_imem_ready) begin
                        r_state    <= ST_DECODE;
                        r_wait     <= '0;
                        o_imem_req <= 1'b0;
                    end else if (r_wait == TMO_LIMIT) begin
                        r_state    <= ST_TRAP;
                        o_imem_req <= 1'b0;
                        o_trap     <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (r_wait == DEC_LIMIT) begin
                        r_wait <= '0;
                        if (w_legal) begin
                            r_state       <= ST_EXEC;
                            r_cls         <= w_class;
                            r_reg_we      <= w_reg_we;
                            r_wb_sel      <= w_wb_sel;
                            r_br_inv      <= w_br_inv;
                            o_alu_op      <= w_alu_op;
                            o_alu_src_imm <= w_alu_src_imm;
                        end else begin
                            r_state <= ST_TRAP;
                            o_trap  <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_EXEC: begin
                    if ((r_cls == CLS_LOAD) || (r_cls == CLS_STORE)) begin
                        r_state    <= ST_MEM;
                        r_wait     <= '0;
                        o_dmem_req <= 1'b1;
                        o_dmem_we  <= (r_cls == CLS_STORE);
                    end else begin
                        r_state        <= ST_WB;
                        o_pc_we        <= 1'b1;
                        o_retired      <= 1'b1;
                        o_retire_count <= o_retire_count + 32'd1;
                        o_reg_we       <= r_reg_we;
                        o_wb_sel       <= r_wb_sel;
                        o_pc_sel       <= w_pc_sel;
                    end
                end
                ST_MEM: begin
                    if (i_dmem_ready) begin
                        r_state        <= ST_WB;
                        o_dmem_req     <= 1'b0;
                        o_dmem_we      <= 1'b0;
                        o_pc_we        <= 1'b1;
                        o_retired      <= 1'b1;
                        o_retire_count <= o_retire_count + 32'd1;
                        o_reg_we       <= r_reg_we;
                        o_wb_sel       <= r_wb_sel;
                        o_pc_sel       <= w_pc_sel;
                    end else if (r_wait == TMO_LIMIT) begin
                        r_state       <= ST_TRAP;
                        o_dmem_req    <= 1'b0;
                        o_dmem_we     <= 1'b0;
                        o_alu_op      <= '0;
                        o_alu_src_imm <= 1'b0;
                        o_trap        <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_WB: begin
                    o_pc_we       <= 1'b0;
                    o_retired     <= 1'b0;
                    o_reg_we      <= 1'b0;
                    o_wb_sel      <= '0;
                    o_pc_sel      <= '0;
                    o_alu_op      <= '0;
                    o_alu_src_imm <= 1'b0;
                    if (i_halt_req) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_wait     <= '0;
                        o_imem_req <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed self-checking bench for core_ctrl_fsm with hand-computed expectations
// for ALU, branch, jump, load/store, timeout, illegal-instruction and reset cases.
module tb_core_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        haltReq;
    logic        imemReq;
    logic        imemReady;
    logic        irLoad;
    logic [37:0] instrBus;
    logic        branchTaken;
    logic [3:0]  aluOp;
    logic        aluSrcImm;
    logic        dmemReq;
    logic        dmemWe;
    logic        dmemReady;
    logic        regWe;
    logic [1:0]  wbSel;
    logic        pcWe;
    logic [1:0]  pcSel;
    logic        trap;
    logic        busy;
    logic        retired;
    logic [31:0] retireCount;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expCount = 0;

    always #5 clk = ~clk;

    core_ctrl_fsm #(.DECODE_LAT(2), .MEM_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_halt_req     (haltReq),
        .o_imem_req     (imemReq),
        .i_imem_ready   (imemReady),
        .o_ir_load      (irLoad),
        .i_instr_bus    (instrBus),
        .i_branch_taken (branchTaken),
        .o_alu_op       (aluOp),
        .o_alu_src_imm  (aluSrcImm),
        .o_dmem_req     (dmemReq),
        .o_dmem_we      (dmemWe),
        .i_dmem_ready   (dmemReady),
        .o_reg_we       (regWe),
        .o_wb_sel       (wbSel),
        .o_pc_we        (pcWe),
        .o_pc_sel       (pcSel),
        .o_trap         (trap),
        .o_busy         (busy),
        .o_retired      (retired),
        .o_retire_count (retireCount)
    );

    // Single comparison point: every check is counted and mismatches are reported here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic hr, input logic imr,
                                 input logic [37:0] ins, input logic bt, input logic dmr);
        start       = st;
        haltReq     = hr;
        imemReady   = imr;
        instrBus    = ins;
        branchTaken = bt;
        dmemReady   = dmr;
    endtask

    // Inputs change and outputs are sampled a few time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, '0, 0, 0);
        step();
        step();
        rst = 1'b0;
        expCount = 0;
    endtask

    function automatic logic [37:0] oneHot(input int idx);
        logic [37:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Non-memory instruction: FETCH(1) DECODE(2) EXEC(1) WB(1), then halt back to IDLE.
    task automatic runSimple(input string name, input int idx, input logic bt,
                             input logic [3:0] expOp, input logic expSrc, input bit chkSrc,
                             input logic expRegWe, input logic [1:0] expWb, input logic [1:0] expPc);
        logic [37:0] v;
        v = oneHot(idx);
        applyStimulus(1, 0, 1, v, bt, 0);
        #1;
        step();
        applyStimulus(0, 0, 1, v, bt, 0);
        #1;
        checkOutput({name, ".ir_load"}, 32'(irLoad), 1);
        checkOutput({name, ".imem_req"}, 32'(imemReq), 1);
        step();
        step();
        step();
        #1;
        checkOutput({name, ".alu_op"}, 32'(aluOp), 32'(expOp));
        if (chkSrc) checkOutput({name, ".alu_src_imm"}, 32'(aluSrcImm), 32'(expSrc));
        checkOutput({name, ".exec_retired"}, 32'(retired), 0);
        step();
        applyStimulus(0, 1, 1, v, bt, 0);
        #1;
        expCount = expCount + 1;
        checkOutput({name, ".reg_we"}, 32'(regWe), 32'(expRegWe));
        checkOutput({name, ".wb_sel"}, 32'(wbSel), 32'(expWb));
        checkOutput({name, ".pc_sel"}, 32'(pcSel), 32'(expPc));
        checkOutput({name, ".retired"}, 32'(retired), 1);
        checkOutput({name, ".pc_we"}, 32'(pcWe), 1);
        checkOutput({name, ".retire_count"}, retireCount, expCount);
        step();
        applyStimulus(0, 0, 0, '0, 0, 0);
        #1;
        checkOutput({name, ".halt_busy"}, 32'(busy), 0);
        checkOutput({name, ".halt_retired"}, 32'(retired), 0);
        checkOutput({name, ".halt_imem_req"}, 32'(imemReq), 0);
    endtask

    // lw with dmem_ready arriving in the third MEM cycle.
    task automatic runLoad();
        logic [37:0] v;
        v = oneHot(21);
        applyStimulus(1, 0, 1, v, 0, 0);
        #1;
        step();
        applyStimulus(0, 0, 1, v, 0, 0);
        step();
        step();
        step();
        #1;
        checkOutput("lw.alu_op", 32'(aluOp), 0);
        checkOutput("lw.alu_src_imm", 32'(aluSrcImm), 1);
        checkOutput("lw.exec_dmem_req", 32'(dmemReq), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            applyStimulus(0, 0, 1, v, 0, (c == 2));
            #1;
            checkOutput($sformatf("lw.mem%0d_dmem_req", c), 32'(dmemReq), 1);
            checkOutput($sformatf("lw.mem%0d_dmem_we", c), 32'(dmemWe), 0);
            checkOutput($sformatf("lw.mem%0d_retired", c), 32'(retired), 0);
        end
        step();
        applyStimulus(0, 1, 1, v, 0, 0);
        #1;
        expCount = expCount + 1;
        checkOutput("lw.wb_dmem_req", 32'(dmemReq), 0);
        checkOutput("lw.wb_sel", 32'(wbSel), 1);
        checkOutput("lw.reg_we", 32'(regWe), 1);
        checkOutput("lw.retired", 32'(retired), 1);
        checkOutput("lw.retire_count", retireCount, expCount);
        step();
        applyStimulus(0, 0, 0, '0, 0, 0);
        #1;
        checkOutput("lw.halt_busy", 32'(busy), 0);
    endtask

    // Illegal decode: trap right after the DECODE window, then start must be ignored.
    task automatic runIllegal(input string name, input logic [37:0] v);
        applyStimulus(1, 0, 1, v, 0, 0);
        #1;
        step();
        applyStimulus(0, 0, 1, v, 0, 0);
        step();
        step();
        #1;
        checkOutput({name, ".decode_trap"}, 32'(trap), 0);
        checkOutput({name, ".decode_busy"}, 32'(busy), 1);
        step();
        #1;
        checkOutput({name, ".trap"}, 32'(trap), 1);
        checkOutput({name, ".busy"}, 32'(busy), 0);
        checkOutput({name, ".imem_req"}, 32'(imemReq), 0);
        checkOutput({name, ".retired"}, 32'(retired), 0);
        checkOutput({name, ".retire_count"}, retireCount, expCount);
        applyStimulus(1, 0, 1, oneHot(0), 0, 0);
        for (int c = 0; c < 3; c++) step();
        #1;
        checkOutput({name, ".start_ignored_trap"}, 32'(trap), 1);
        checkOutput({name, ".start_ignored_busy"}, 32'(busy), 0);
        checkOutput({name, ".start_ignored_imem_req"}, 32'(imemReq), 0);
        applyStimulus(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        applyStimulus(0, 0, 0, '0, 0, 0);
        #3;
        checkOutput("reset.imem_req", 32'(imemReq), 0);
        checkOutput("reset.busy", 32'(busy), 0);
        checkOutput("reset.trap", 32'(trap), 0);
        checkOutput("reset.retire_count", retireCount, 0);
        checkOutput("reset.pc_we", 32'(pcWe), 0);
        applyReset();

        //          name       bit bt  op  src chk  rwe wb  pc
        runSimple("add",      0,  0, 0,  0, 1,   1,  0,  0);
        runSimple("sra",      7,  0, 7,  0, 1,   1,  0,  0);
        runSimple("xori",     11, 0, 2,  1, 1,   1,  0,  0);
        runSimple("slti",     17, 0, 8,  1, 1,   1,  0,  0);
        runSimple("bne_nt",   28, 0, 1,  0, 1,   0,  0,  1);
        runSimple("bne_t",    28, 1, 1,  0, 1,   0,  0,  0);
        runSimple("beq_t",    27, 1, 1,  0, 1,   0,  0,  1);
        runSimple("blt_t",    29, 1, 8,  0, 1,   0,  0,  1);
        runSimple("bgeu_nt",  32, 0, 9,  0, 1,   0,  0,  1);
        runSimple("jal",      33, 0, 0,  0, 0,   1,  2,  1);
        runSimple("jalr",     34, 0, 0,  1, 1,   1,  2,  2);
        runSimple("lui",      35, 0, 0,  0, 0,   1,  3,  0);
        runSimple("auipc",    36, 0, 0,  0, 0,   1,  0,  0);
        runLoad();

        // Reset during a store's MEM phase must drop the request without a clock edge.
        applyStimulus(1, 0, 1, oneHot(26), 0, 0);
        #1;
        step();
        applyStimulus(0, 0, 1, oneHot(26), 0, 0);
        for (int c = 0; c < 5; c++) step();
        #1;
        checkOutput("sw_rst.pre_dmem_req", 32'(dmemReq), 1);
        checkOutput("sw_rst.pre_dmem_we", 32'(dmemWe), 1);
        rst = 1'b1;
        #1;
        checkOutput("sw_rst.dmem_req", 32'(dmemReq), 0);
        checkOutput("sw_rst.dmem_we", 32'(dmemWe), 0);
        checkOutput("sw_rst.busy", 32'(busy), 0);
        checkOutput("sw_rst.retire_count", retireCount, 0);
        applyReset();

        runSimple("add2", 0, 0, 0, 0, 1, 1, 0, 0);

        // sw with dmem_ready never arriving: 16 MEM cycles, then TRAP.
        applyStimulus(1, 0, 1, oneHot(26), 0, 0);
        #1;
        step();
        applyStimulus(0, 0, 1, oneHot(26), 0, 0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmemReq) n++;
            if (trap) break;
            step();
        end
        checkOutput("sw_tmo.req_cycles", 32'(n), 16);
        checkOutput("sw_tmo.trap", 32'(trap), 1);
        checkOutput("sw_tmo.dmem_req", 32'(dmemReq), 0);
        checkOutput("sw_tmo.busy", 32'(busy), 0);
        checkOutput("sw_tmo.retire_count", retireCount, expCount);
        applyStimulus(0, 0, 0, '0, 0, 0);

        applyReset();
        #1;
        checkOutput("rst2.trap", 32'(trap), 0);
        runSimple("add3", 0, 0, 0, 0, 1, 1, 0, 0);
        runIllegal("zero", '0);
        applyReset();
        runSimple("add4", 0, 0, 0, 0, 1, 1, 0, 0);
        runIllegal("twohot", 38'h3);
        applyReset();
        runIllegal("rsvd", oneHot(37));
        applyReset();

        // imem_ready held low: 16 FETCH cycles of imem_req, then TRAP.
        applyStimulus(1, 0, 0, oneHot(0), 0, 0);
        #1;
        step();
        applyStimulus(0, 0, 0, oneHot(0), 0, 0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (imemReq) n++;
            if (irLoad) checkOutput("imem_tmo.ir_load", 32'(irLoad), 0);
            if (trap) break;
            step();
        end
        checkOutput("imem_tmo.req_cycles", 32'(n), 16);
        checkOutput("imem_tmo.trap", 32'(trap), 1);
        checkOutput("imem_tmo.imem_req", 32'(imemReq), 0);
        checkOutput("imem_tmo.busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
